// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// State encoding and default sizing.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 6;

endpackage

// File: rtl/fullAdder.sv
// Single-bit full adder cell.
// Leaf of the ripple adder chain.
module fullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/ripple_adder.sv
// WIDTH-bit ripple-carry adder built from fullAdder cells.
// Shared by every add/shift iteration of the multiplier.
module ripple_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] c;

    assign c[0] = cin;
    assign cout = c[WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        fullAdder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .sum  (sum[i]),
            .cout (c[i+1])
        );
    end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential shift-add MULT/MULTU unit with start/busy/done handshake.
// Magnitudes are multiplied unsigned; the sign is fixed up in one SIGN cycle.
module mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sign_en,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] p;
    logic               neg;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               cout;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic               neg_in;

    assign addend = p[0] ? mcand : '0;
    assign abs_a  = (sign_en && op_a[WIDTH-1]) ? -op_a : op_a;
    assign abs_b  = (sign_en && op_b[WIDTH-1]) ? -op_b : op_b;
    assign neg_in = sign_en & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);

    assign hi = p[2*WIDTH-1:WIDTH];
    assign lo = p[WIDTH-1:0];

    ripple_adder #(.WIDTH(WIDTH)) u_add (
        .a    (p[2*WIDTH-1:WIDTH]),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
            mcand <= '0;
            p     <= '0;
            neg   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mcand <= abs_a;
                        p     <= {{WIDTH{1'b0}}, abs_b};
                        neg   <= neg_in;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    // carry-out lands in the top bit so no product bit is lost
                    p   <= {cout, sum, p[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1))
                        state <= SIGN;
                end
                SIGN: begin
                    if (neg)
                        p <= ~p + 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: vector table, random ops
// against a behavioural product, and handshake/reset sequences.
module tb_mult_seq_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         sign_en;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_chk  = 0;
    int n_fail = 0;

    logic [2*W-1:0] sb[$];

    typedef struct {
        logic         s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] eh;
        logic [W-1:0] el;
    } vec_t;

    vec_t tbl[8];

    always #5 clk = ~clk;

    mult_seq_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .sign_en (sign_en),
        .op_a    (op_a),
        .op_b    (op_b),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a request and record its expected product.
    task automatic issue(input logic s, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [2*W-1:0] exp);
        start   = 1'b1;
        sign_en = s;
        op_a    = a;
        op_b    = b;
        sb.push_back(exp);
    endtask

    // Called just after the accepting edge; returns in the done cycle.
    task automatic wait_done(input string nm, input bit poke);
        int  n;
        bit  seen;
        bit  busy_ok;
        logic [2*W-1:0] exp;
        seen    = 0;
        busy_ok = 1;
        n       = 0;
        for (int i = 1; i <= W + 8; i++) begin
            if (poke && (i == 5 || i == 20)) begin
                start = 1'b1;
                op_a  = 32'h0000_0003;
                op_b  = 32'h0000_0007;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done) begin
                seen = 1;
                n    = i;
                break;
            end
            if (!busy) busy_ok = 0;
        end
        start = 1'b0;
        chk({nm, "_seen"}, 64'(seen), 64'd1);
        chk({nm, "_lat"}, 64'(n), 64'(W + 1));
        if (poke)
            chk({nm, "_busy_cont"}, 64'(busy_ok), 64'd1);
        if (sb.size() == 0) begin
            chk({nm, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            exp = sb.pop_front();
            chk({nm, "_prod"}, {hi, lo}, exp);
        end
        chk({nm, "_busy_low"}, 64'(busy), 64'd0);
    endtask

    function automatic logic [2*W-1:0] model(input logic s,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic signed [2*W-1:0] sa;
        logic signed [2*W-1:0] sbv;
        if (s) begin
            sa  = {{W{a[W-1]}}, a};
            sbv = {{W{b[W-1]}}, b};
            return sa * sbv;
        end
        return {{W{1'b0}}, a} * {{W{1'b0}}, b};
    endfunction

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;
        bit           stray;

        tbl[0] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        tbl[1] = '{1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        tbl[2] = '{1'b0, 32'hFFFF_FFFD, 32'h0000_0005, 32'h0000_0004, 32'hFFFF_FFF1};
        tbl[3] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        tbl[4] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000};
        tbl[5] = '{1'b0, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000};
        tbl[6] = '{1'b1, 32'h0000_0001, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678};
        tbl[7] = '{1'b1, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};

        rst_n   = 1'b0;
        start   = 1'b0;
        sign_en = 1'b0;
        op_a    = '0;
        op_b    = '0;
        tick();
        tick();
        chk("rst_state", {30'd0, busy, done, hi}, 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            issue(tbl[i].s, tbl[i].a, tbl[i].b, {tbl[i].eh, tbl[i].el});
            tick();
            start = 1'b0;
            chk($sformatf("vec%0d_busy", i), 64'(busy), 64'd1);
            wait_done($sformatf("vec%0d", i), 0);
            tick();
            chk($sformatf("vec%0d_pulse", i), 64'(done), 64'd0);
        end

        for (int i = 0; i < 6; i++) begin
            ra = $urandom();
            rb = $urandom();
            rs = 1'($urandom_range(0, 1));
            issue(rs, ra, rb, model(rs, ra, rb));
            tick();
            start = 1'b0;
            wait_done($sformatf("rnd%0d", i), 0);
            tick();
        end

        // start pulses during RUN are ignored
        issue(1'b1, 32'hFFFF_FFF9, 32'h0000_0011,
              model(1'b1, 32'hFFFF_FFF9, 32'h0000_0011));
        tick();
        wait_done("ignore", 1);
        tick();
        chk("ignore_single_done", {62'd0, busy, done}, 64'd0);

        // back-to-back: start held in the DONE cycle
        issue(1'b0, 32'h0000_1234, 32'h0000_5678, 64'h0000_0000_0626_0060);
        tick();
        wait_done("b2b_first", 0);
        issue(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);
        tick();
        start = 1'b0;
        chk("b2b_busy", {62'd0, busy, done}, 64'd2);
        wait_done("b2b_second", 0);
        tick();

        // reset during RUN aborts with no done
        issue(1'b0, 32'hDEAD_BEEF, 32'h0000_0003, 64'd0);
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        void'(sb.pop_front());
        chk("abort_ctl", {62'd0, busy, done}, 64'd0);
        chk("abort_prod", {hi, lo}, 64'd0);
        stray = 0;
        for (int i = 0; i < W + 8; i++) begin
            tick();
            if (done || busy) stray = 1;
        end
        chk("abort_no_done", 64'(stray), 64'd0);

        issue(1'b1, 32'h0000_0007, 32'hFFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFD6);
        tick();
        start = 1'b0;
        wait_done("after_abort", 0);
        tick();

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
